serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_sub_pkg.sv | 13 +
 rtl/full_subtractor.sv | 14 +
 rtl/serial_subtractor.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding
// and the default operand width.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int SERIAL_SUB_WIDTH_DEF = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: computes a_in - b_in - bw_in.
// It produces the difference bit and the borrow into the next bit.
module full_subtractor (
  input  logic a_in,
  input  logic b_in,
  input  logic bw_in,
  output logic diff_out,
  output logic bw_out
);

  assign diff_out = a_in ^ b_in ^ bw_in;
  assign bw_out   = (~a_in & b_in) | (~(a_in ^ b_in) & bw_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a-b one bit per clock, LSB first, using a
// single full_subtractor cell. A full operation takes WIDTH+2 cycles:
// one accept cycle in IDLE, WIDTH RUN cycles and one DONE cycle.
// busy and done are registered copies of the state, so they appear one
// cycle after the state that produces them.
// Optional feature: define SERIAL_SUB_OVF_EN to add the signed-overflow
// output ovf.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SERIAL_SUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bw_q, bw_d;
  logic             borrow_q, borrow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cell_d;
  logic             cell_bw;
  logic [WIDTH-1:0] res_next;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  full_subtractor u_cell (
    .a_in    (a_sh_q[0]),
    .b_in    (b_sh_q[0]),
    .bw_in   (bw_q),
    .diff_out(cell_d),
    .bw_out  (cell_bw)
  );

  assign res_next = {cell_d, res_q[WIDTH-1:1]};

  // Next-state and datapath: accept in IDLE, one bit per RUN cycle, publish on RUN->DONE
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    diff_d   = diff_q;
    bw_d     = bw_q;
    borrow_d = borrow_q;
    busy_d   = (state_q != S_IDLE);
    done_d   = (state_q == S_DONE);
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          bw_d    = 1'b0;
          cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end
      end
      S_RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        bw_d   = cell_bw;
        res_d  = res_next;
        if (cnt_q == CNT_LAST) begin
          state_d  = S_DONE;
          diff_d   = res_next;
          borrow_d = cell_bw;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d    = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      bw_q     <= 1'b0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      bw_q     <= bw_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf        = ovf_q;
`endif

endmodule
